// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds bytes from four requesters
// into a downstream UART buffer. Each granted requester holds the grant for a
// whole message. Each byte is written with a baud-paced strobe: high for one
// baud period, then low for one baud period. The arbiter also tracks how many
// bytes are outstanding in the buffer.
// Optional feature: define UART_ARB_TIMEOUT_EN to add a stall watchdog and the
// arb_timeout output.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int BUF_DEPTH     = 255,
  parameter int TIMEOUT_TICKS = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   baud_x1,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     gnt,
  input  logic                   tx_pop,
  output logic [7:0]             buf_data,
  output logic                   buf_strobe,
`ifdef UART_ARB_TIMEOUT_EN
  output logic                   arb_timeout,
`endif
  output logic [7:0]             buf_level
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [7:0] DEPTH = 8'(BUF_DEPTH);

  if (NUM_REQ != 4) begin : g_chk_num_req
    $error("uart_tx_arbiter: NUM_REQ must be 4");
  end
  if (BUF_DEPTH < 1 || BUF_DEPTH > 255) begin : g_chk_depth
    $error("uart_tx_arbiter: BUF_DEPTH must fit the 8-bit level counter");
  end
  if (TIMEOUT_TICKS < 1) begin : g_chk_timeout
    $error("uart_tx_arbiter: TIMEOUT_TICKS must be positive");
  end

  typedef enum logic [2:0] {IDLE, ARB, WAIT_BYTE, STROBE_HI, STROBE_LO} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         data_q, data_d;
  logic [7:0]         level_q, level_d;
  logic               last_q, last_d;
  logic               strobe_q, strobe_d;
  logic               accept;
  logic               pop_ok;
  logic               cur_req;
  logic               cur_valid;
  logic [7:0]         cur_byte;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_TICKS + 1);
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               timeout;
`endif

  // Pick the first asserted request searching from (p + 1) upward, wrapping.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] idx;
    rr_pick = p;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IDX_W'((int'(p) + i) % NUM_REQ);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign cur_req   = req[gidx_q];
  assign cur_valid = req_valid[gidx_q];
  assign cur_byte  = req_data[8*int'(gidx_q) +: 8];

  // Next-state logic: arbitration, byte hand-off and strobe pacing.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    last_d    = last_q;
    accept    = 1'b0;
    req_ready = '0;
`ifdef UART_ARB_TIMEOUT_EN
    wd_d      = '0;
    timeout   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) state_d = ARB;
      end
      ARB: begin
        if (|req) begin
          gidx_d  = rr_pick(req, ptr_q);
          ptr_d   = gidx_d;
          gnt_d   = NUM_REQ'(1) << gidx_d;
          state_d = WAIT_BYTE;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_BYTE: begin
`ifdef UART_ARB_TIMEOUT_EN
        wd_d = wd_q;
        if (baud_x1 && !cur_valid) wd_d = wd_q + 1'b1;
`endif
        if (!cur_req) begin
          // Holder abandoned the message between bytes: release now.
          gnt_d   = '0;
          state_d = IDLE;
        end else if (cur_valid && (level_q < DEPTH)) begin
          accept    = 1'b1;
          req_ready = gnt_q;
          data_d    = cur_byte;
          last_d    = req_last[gidx_q];
          state_d   = STROBE_HI;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (baud_x1 && !cur_valid && (wd_q == WD_W'(TIMEOUT_TICKS - 1))) begin
          timeout = 1'b1;
          gnt_d   = '0;
          state_d = IDLE;
        end
`endif
      end
      STROBE_HI: begin
        if (baud_x1) state_d = STROBE_LO;
      end
      STROBE_LO: begin
        if (baud_x1) begin
          // A dropped request is only honoured once the byte in flight is done.
          if (last_q || !cur_req) begin
            gnt_d   = '0;
            state_d = IDLE;
          end else begin
            state_d = WAIT_BYTE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Level moves by +1 per accepted byte and -1 per pop; a pop when empty is dropped.
  always_comb begin
    pop_ok   = tx_pop && (level_q != 8'd0);
    level_d  = level_q + {7'd0, accept} - {7'd0, pop_ok};
    strobe_d = (state_d == STROBE_HI);
  end

  // State and output registers; reset aborts any message in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gidx_q   <= '0;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      data_q   <= 8'h00;
      last_q   <= 1'b0;
      level_q  <= 8'd0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      last_q   <= last_d;
      level_q  <= level_d;
      strobe_q <= strobe_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Watchdog over baud ticks spent waiting on a silent grant holder.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wd_q <= '0;
    else        wd_q <= wd_d;
  end

  assign arb_timeout = timeout;
`endif

  assign gnt        = gnt_q;
  assign buf_data   = data_q;
  assign buf_strobe = strobe_q;
  assign buf_level  = level_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: queue-driven requester models, a byte
// scoreboard checked on every buf_strobe rising edge, and directed scenarios.
// Define UART_ARB_TIMEOUT_EN to also cover the watchdog.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TOUT = 4;
`else
  localparam int TOUT = 1024;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        baud_x1 = 1'b0;
  logic        tx_pop = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [3:0]  gnt;
  logic [7:0]  buf_data;
  logic [7:0]  buf_level;
  logic        buf_strobe;
`ifdef UART_ARB_TIMEOUT_EN
  logic        arb_timeout;
`endif

  uart_tx_arbiter #(
    .NUM_REQ(NREQ),
    .BUF_DEPTH(255),
    .TIMEOUT_TICKS(TOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .baud_x1(baud_x1),
    .req(req),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .gnt(gnt),
    .tx_pop(tx_pop),
    .buf_data(buf_data),
    .buf_strobe(buf_strobe),
`ifdef UART_ARB_TIMEOUT_EN
    .arb_timeout(arb_timeout),
`endif
    .buf_level(buf_level)
  );

  always #5 clk = ~clk;

  typedef logic [8:0] byteq_t[$];
  byteq_t      txq [NREQ];
  logic [9:0]  sb [$];
  logic [3:0]  silent = '0;
  logic [3:0]  rdy_seen = '0;
  logic        strobe_prev = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          baud_cnt = 0;
  int          last_rise = 0;
  int          nrise = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++)
      if (txq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Baud generator bookkeeping: count ticks at the clock edge that consumes them.
  initial begin : baud_counter
    forever begin
      @(posedge clk);
      if (baud_x1) baud_cnt++;
    end
  end

  // Requester models and baud generator, driven on the falling edge.
  initial begin : driver
    int div;
    logic [8:0] h;
    div = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (rdy_seen[i] && txq[i].size() > 0) void'(txq[i].pop_front());
        h = (txq[i].size() > 0) ? txq[i][0] : 9'h000;
        req[i]             = (txq[i].size() > 0) || silent[i];
        req_valid[i]       = (txq[i].size() > 0) && !silent[i];
        req_data[8*i +: 8] = h[7:0];
        req_last[i]        = h[8];
      end
      baud_x1 = (div == 3);
      div = (div + 1) % 4;
      #1 rdy_seen = req_ready;
    end
  end

  // Scoreboard: every strobe rising edge must carry the next expected byte/owner.
  initial begin : monitor
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (buf_strobe && !strobe_prev) begin
        if (sb.size() == 0) begin
          chk("sb_underrun", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("byte_data", buf_data, e[7:0]);
          chk("byte_owner", gnt, 32'(1) << e[9:8]);
        end
        if (nrise > 0) chk("strobe_gap_ge2", (baud_cnt - last_rise) >= 2, 1);
        last_rise = baud_cnt;
        nrise++;
      end
      strobe_prev = buf_strobe;
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) txq[i].delete();
    sb.delete();
    silent = '0;
    tx_pop = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int maxc, input bit pop_on_acc);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < maxc) begin
      @(negedge clk);
      #2;
      tx_pop = pop_on_acc && (req_ready != 4'b0000);
      n++;
      if (sb.size() == 0 && all_empty() && gnt == 4'b0000 && !buf_strobe) done = 1'b1;
    end
    tx_pop = 1'b0;
    chk({tag, "_done"}, done, 1);
  endtask

  initial begin : global_guard
    #600000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int n;
    int m;
    int stall_rdy;
    int b0;

    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_strobe", buf_strobe, 0);
    chk("rst_data", buf_data, 0);
    chk("rst_level", buf_level, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single requester sends "OK"
    txq[0].push_back({1'b0, 8'h4F});
    txq[0].push_back({1'b1, 8'h4B});
    sb.push_back({2'd0, 8'h4F});
    sb.push_back({2'd0, 8'h4B});
    #2;
    n = 0;
    while (req == 4'b0000 && n < 10) begin @(negedge clk); #2; n++; end
    m = 0;
    while (gnt == 4'b0000 && m < 10) begin @(negedge clk); #2; m++; end
    chk("req_to_gnt_latency", m, 2);
    wait_idle("msg_ok", 200, 1'b0);
    chk("ok_gnt_released", gnt, 0);
    chk("ok_level", buf_level, 2);

    // Three pops from level 2: the last one must be ignored
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #2 tx_pop = 1'b1;
      @(negedge clk); #2 tx_pop = 1'b0;
    end
    chk("pop_underflow_level", buf_level, 0);

    // Contention from reset: order 0,1,2,3
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      txq[i].push_back({1'b1, 8'hA0 + 8'(i)});
      sb.push_back({2'(i), 8'hA0 + 8'(i)});
    end
    wait_idle("contend", 400, 1'b0);

    // Requester 2 re-requests at once; 3 must win in between
    txq[2].push_back({1'b1, 8'hC0});
    txq[2].push_back({1'b1, 8'hC1});
    txq[3].push_back({1'b1, 8'hD0});
    sb.push_back({2'd2, 8'hC0});
    sb.push_back({2'd3, 8'hD0});
    sb.push_back({2'd2, 8'hC1});
    wait_idle("rerequest", 400, 1'b0);
    chk("rerequest_level", buf_level, 7);

    // Lock: 3-byte message from 1 while 0 waits; pops coincide with accepts
    txq[1].push_back({1'b0, 8'hB0});
    txq[1].push_back({1'b0, 8'hB1});
    txq[1].push_back({1'b1, 8'hB2});
    sb.push_back({2'd1, 8'hB0});
    sb.push_back({2'd1, 8'hB1});
    sb.push_back({2'd1, 8'hB2});
    n = 0;
    while (gnt != 4'b0010 && n < 20) begin
      @(negedge clk); #2;
      tx_pop = (req_ready != 4'b0000);
      n++;
    end
    chk("lock_grant1", gnt, 4'b0010);
    txq[0].push_back({1'b1, 8'hE0});
    sb.push_back({2'd0, 8'hE0});
    wait_idle("lock", 400, 1'b1);
    chk("lock_level_simul_incdec", buf_level, 7);

    // Buffer full: 256 bytes offered, 255 accepted, one pop frees the last
    do_reset();
    for (int k = 0; k < 256; k++) begin
      txq[0].push_back({(k == 255), 8'(k)});
      sb.push_back({2'd0, 8'(k)});
    end
    n = 0;
    while (buf_level != 8'd255 && n < 5000) begin @(negedge clk); #2; n++; end
    chk("full_reached", buf_level, 255);
    stall_rdy = 0;
    repeat (40) begin
      @(negedge clk); #2;
      if (req_ready != 4'b0000) stall_rdy++;
    end
    chk("full_no_ready", stall_rdy, 0);
    chk("full_level_held", buf_level, 255);
    chk("full_stalled_bytes", txq[0].size(), 1);
    chk("full_gnt_held", gnt, 4'b0001);
    @(negedge clk); #2 tx_pop = 1'b1;
    @(negedge clk); #2 tx_pop = 1'b0;
    wait_idle("full_drain", 200, 1'b0);
    chk("full_level_after_pop", buf_level, 255);

    // Asynchronous reset in the middle of a strobe
    do_reset();
    txq[0].push_back({1'b1, 8'h5A});
    sb.push_back({2'd0, 8'h5A});
    n = 0;
    while (!buf_strobe && n < 50) begin @(negedge clk); #2; n++; end
    chk("mid_strobe_reached", buf_strobe, 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_strobe", buf_strobe, 0);
    chk("arst_gnt", gnt, 0);
    chk("arst_level", buf_level, 0);
    for (int i = 0; i < NREQ; i++) txq[i].delete();
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = nrise;
    repeat (30) @(negedge clk);
    #2;
    chk("no_resume_strobes", nrise - n, 0);
    chk("no_resume_gnt", gnt, 0);

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog: requester 1 granted but silent, requester 2 waiting
    do_reset();
    silent[1] = 1'b1;
    txq[2].push_back({1'b1, 8'h77});
    sb.push_back({2'd2, 8'h77});
    n = 0;
    while (gnt != 4'b0010 && n < 20) begin @(negedge clk); #2; n++; end
    chk("to_first_gnt", gnt, 4'b0010);
    b0 = baud_cnt;
    n = 0;
    while (!arb_timeout && n < 100) begin @(negedge clk); #2; n++; end
    chk("to_pulse", arb_timeout, 1);
    chk("to_ticks", baud_cnt - b0 + 1, 4);
    @(negedge clk); #2;
    chk("to_pulse_width", arb_timeout, 0);
    silent[1] = 1'b0;
    n = 0;
    while (gnt != 4'b0100 && n < 20) begin @(negedge clk); #2; n++; end
    chk("to_next_gnt", gnt, 4'b0100);
    wait_idle("to_drain", 200, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters, fixed at 4 for this revision.
REQ-002 Parameter BUF_DEPTH, 255, maximum bytes outstanding in the downstream uart_buffer.
REQ-003 Parameter TIMEOUT_TICKS, 1024, watchdog limit in baud_x1 ticks (used only with UART_ARB_TIMEOUT_EN).
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted = 0).
REQ-006 baud_x1  in  1  one-clk pulse per UART bit period, from the buffer's uart_clk.
REQ-007 req  in  4  per-requester message request; held high for the whole message.
REQ-008 req_valid  in  4  per-requester byte valid.
REQ-009 req_data  in  32  byte for requester i is on req_data[8i+7:8i].
REQ-010 req_last  in  4  marks the final byte of a message; qualified by req_valid.
REQ-011 req_ready  out  4  one-clk pulse: byte accepted from the granted requester.
REQ-012 gnt  out  4  one-hot grant, or all zero.
REQ-013 tx_pop  in  1  one-clk pulse per byte the buffer hands to uart_tx.
REQ-014 buf_data  out  8  byte to the buffer write port.
REQ-015 buf_strobe  out  1  write strobe to the buffer; paced to baud_x1.
REQ-016 buf_level  out  8  bytes written but not yet popped.

Function
REQ-017 FSM states: IDLE, ARB, WAIT_BYTE, STROBE_HI, STROBE_LO.
REQ-018 IDLE: go to ARB on the next clk when req != 0.
REQ-019 ARB: grant the highest-priority asserted req in round-robin order, starting at (last winner + 1) mod 4; set gnt one-hot; go to WAIT_BYTE.
REQ-020 WAIT_BYTE: if req_valid[g] and buf_level < BUF_DEPTH, latch the byte into buf_data, pulse req_ready[g] for one clk, and go to STROBE_HI.
REQ-021 WAIT_BYTE with the buffer full: hold, with no req_ready pulse.
REQ-022 STROBE_HI: buf_strobe = 1 until the first baud_x1 pulse after entry, then go to STROBE_LO.
REQ-023 STROBE_LO: buf_strobe = 0 until the next baud_x1 pulse, which guarantees the buffer sees a rising edge per byte.
REQ-024 STROBE_LO exit, latched byte had req_last: drop gnt and go to IDLE.
REQ-025 STROBE_LO exit, otherwise: go to WAIT_BYTE.
REQ-026 A grant is locked for a whole message; other requesters' bytes are never interleaved.
REQ-027 buf_level increments on entry to STROBE_HI and decrements on tx_pop.
REQ-028 Simultaneous increment and decrement leaves buf_level unchanged.
REQ-029 A tx_pop at buf_level = 0 is ignored, with no underflow.
REQ-030 buf_level never exceeds BUF_DEPTH.
REQ-031 req[g] dropped mid-message before last: finish any byte in flight, then release gnt and go to IDLE; the round-robin pointer advances.
REQ-032 Minimum per-byte cost is 2 baud_x1 periods; the latency from req to first gnt is 2 clk from IDLE.

Reset
REQ-033 While reset = 0: state = IDLE, gnt = 0, req_ready = 0, buf_strobe = 0, buf_data = 8'h00, buf_level = 0, round-robin pointer = 3 (so requester 0 wins first).
REQ-034 Reset assertion mid-message aborts immediately; the partial message is not resumed after release.
REQ-035 Outputs are glitch-free after reset release; the first transition occurs on the first clk edge with reset = 1.

Configuration
REQ-036 With macro UART_ARB_TIMEOUT_EN defined, a watchdog counts baud_x1 ticks spent in WAIT_BYTE without req_valid[g] and restarts on every accepted byte.
REQ-037 Watchdog expiry at TIMEOUT_TICKS: release gnt, go to IDLE, advance the pointer, and pulse the extra output arb_timeout for one clk.
REQ-038 Without UART_ARB_TIMEOUT_EN: no counter and no arb_timeout port; a stalled holder keeps the grant indefinitely.

Verification
REQ-039 Single requester: req[0] sends "OK" (8'h4F, then 8'h4B with last) -> buf_data 4F then 4B, 2 buf_strobe rising edges at least 2 baud_x1 apart, gnt back to 0, buf_level = 2.
REQ-040 Contention: req = 4'b1111 at once, each with a 1-byte message -> grant order 0, 1, 2, 3.
REQ-041 Requester 2 re-requests immediately -> requester 3 still wins before 2.
REQ-042 Lock: req[1] 3-byte message with req[0] asserted throughout -> bytes of requester 1 are contiguous; requester 0 is granted only after last.
REQ-043 Full: no tx_pop, 256 bytes offered -> exactly 255 accepted and the 256th is stalled; one tx_pop -> it is accepted and buf_level returns to 255.
REQ-044 Reset mid-strobe: reset = 0 during STROBE_HI -> buf_strobe = 0 and gnt = 0 asynchronously, and buf_level = 0.
REQ-045 UART_ARB_TIMEOUT_EN, TIMEOUT_TICKS = 4: granted requester goes silent -> arb_timeout pulse after 4 baud_x1 ticks, and the next requester is granted.
